parallel_adder: RTL and testbench

- 8-bit unsigned parallel adder with registered result; top-level user block on the project's tile I/O harness.
- Operand A arrives on ui_in and operand B on uio_in. The 8-bit sum is driven on uo_out and the carry-out on uio_out.
- The adder core is a structural ripple-carry chain of full-adder cells. The sum and carry registers are updated only when the 1-bit strobe uio_oe is high.

---
 rtl/parallel_adder.sv | 66 ++++++
 tb/tb_parallel_adder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/parallel_adder.sv
`default_nettype none
// ============================================================================
// Module   : parallel_adder
// Purpose  : 8-bit unsigned ripple-carry adder with a strobed registered result.
//            Define PARALLEL_ADDER_SAT_EN to clamp overflowing sums to 8'hFF.
// Revision : 1.0 - initial release
// ============================================================================

module parallel_adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module parallel_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ui_in,
  input  logic [WIDTH-1:0] uio_in,
  input  logic             uio_oe,
  output logic [WIDTH-1:0] uo_out,
  output logic             uio_out
);

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_result;

  assign w_carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa_chain
    parallel_adder_fa u_fa (
      .a  (ui_in[i]),
      .b  (uio_in[i]),
      .ci (w_carry[i]),
      .s  (w_sum[i]),
      .co (w_carry[i+1])
    );
  end

`ifdef PARALLEL_ADDER_SAT_EN
  // Carry-out doubles as the saturation flag, so the clamp keys off it directly.
  assign w_result = w_carry[WIDTH] ? {WIDTH{1'b1}} : w_sum;
`else
  assign w_result = w_sum;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      uo_out  <= '0;
      uio_out <= 1'b0;
    end else if (uio_oe) begin
      uo_out  <= w_result;
      uio_out <= w_carry[WIDTH];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_parallel_adder.sv
`default_nettype none
// Self-checking bench for parallel_adder: directed plan steps, random traffic
// and a full operand sweep, all checked against an arithmetic reference model.

module tb_parallel_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic       uio_oe = 1'b0;
  logic [7:0] uo_out;
  logic       uio_out;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_s = 8'h00;
  logic       m_c = 1'b0;

  parallel_adder #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uio_oe  (uio_oe),
    .uo_out  (uo_out),
    .uio_out (uio_out)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_out(input string tag, input logic [7:0] es, input logic ec);
    checks++;
    assert (uo_out === es) else begin
      failures++;
      $error("FAIL %s uo_out: got %h want %h", tag, uo_out, es);
    end
    checks++;
    assert (uio_out === ec) else begin
      failures++;
      $error("FAIL %s uio_out: got %b want %b", tag, uio_out, ec);
    end
  endtask

  // Drive one cycle, advance the reference model on the edge, compare after it.
  task automatic step(input string tag, input logic r, input logic [7:0] a,
                      input logic [7:0] b, input logic oe);
    logic [8:0] total;
    rst_n  = r;
    ui_in  = a;
    uio_in = b;
    uio_oe = oe;
    @(posedge clk);
    if (!r) begin
      m_s = 8'h00;
      m_c = 1'b0;
    end else if (oe) begin
      total = 9'(a) + 9'(b);
      m_c = (total >= 9'd256);
`ifdef PARALLEL_ADDER_SAT_EN
      m_s = m_c ? 8'hFF : total[7:0];
`else
      m_s = 8'(total % 9'd256);
`endif
    end
    #1;
    check_out(tag, m_s, m_c);
  endtask

  initial begin
    // Reset with live operands and strobe high
    step("reset0", 1'b0, 8'hAA, 8'h55, 1'b1);
    step("reset1", 1'b0, 8'hAA, 8'h55, 1'b1);
    check_out("reset_const", 8'h00, 1'b0);

    step("basic", 1'b1, 8'h12, 8'h34, 1'b1);
    check_out("basic_const", 8'h46, 1'b0);

    for (int i = 0; i < 3; i++) begin
      step("hold", 1'b1, 8'h80, 8'h80, 1'b0);
      check_out("hold_const", 8'h46, 1'b0);
    end

    step("hold_release", 1'b1, 8'h80, 8'h80, 1'b1);
`ifdef PARALLEL_ADDER_SAT_EN
    check_out("release_const", 8'hFF, 1'b1);
`else
    check_out("release_const", 8'h00, 1'b1);
`endif

    step("wrap", 1'b1, 8'hFF, 8'h01, 1'b1);
`ifdef PARALLEL_ADDER_SAT_EN
    check_out("wrap_const", 8'hFF, 1'b1);
`else
    check_out("wrap_const", 8'h00, 1'b1);
`endif

    step("max", 1'b1, 8'hFF, 8'hFF, 1'b1);
`ifdef PARALLEL_ADDER_SAT_EN
    check_out("max_const", 8'hFF, 1'b1);
`else
    check_out("max_const", 8'hFE, 1'b1);
`endif

    step("zero", 1'b1, 8'h00, 8'h00, 1'b1);
    check_out("zero_const", 8'h00, 1'b0);

    step("mid_reset_strobe_low", 1'b1, 8'h7F, 8'h01, 1'b1);
    step("mid_reset_strobe_low", 1'b0, 8'hC3, 8'h77, 1'b0);
    check_out("mid_reset_const", 8'h00, 1'b0);
    step("post_reset", 1'b1, 8'h01, 8'h02, 1'b1);
    check_out("post_reset_const", 8'h03, 1'b0);

    // Random traffic: occasional reset, strobe about 2/3 of the time
    for (int i = 0; i < 400; i++) begin
      step("random", ($urandom_range(0, 19) != 0), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 2) != 0));
    end

    // Full operand sweep with a reset pulse inserted mid-stream
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        if (a == 120 && b == 37) begin
          step("sweep_reset", 1'b0, 8'(a), 8'(b), 1'b1);
          check_out("sweep_reset_const", 8'h00, 1'b0);
        end
        step("sweep", 1'b1, 8'(a), 8'(b), 1'b1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
